mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the PicoRV32 native memory interface (valid/ready, addr, wdata, wstrb, rdata, instr).
- Lets the CPU core (M0) and a secondary master (M1: DMA, debug or loader) share one memory/peripheral port inside `main`.
- Round-robin fairness; grant held for the whole transaction.
- Per-transaction timeout returns an error pulse instead of hanging the bus.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- TIMEOUT, 255, max cycles the granted transaction waits for s_ready; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- nreset  in  1  asynchronous active-low reset.
- m0_valid  in  1  M0 request; held until m0_ready or m0_err.
- m0_instr  in  1  M0 instruction-fetch flag.
- m0_addr  in  ADDR_WIDTH  M0 address.
- m0_wdata  in  DATA_WIDTH  M0 write data.
- m0_wstrb  in  DATA_WIDTH/8  M0 byte strobes; all 0 means read.
- m0_ready  out  1  M0 completion, one cycle.
- m0_err  out  1  M0 timeout completion, one cycle.
- m0_rdata  out  DATA_WIDTH  M0 read data.
- m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_err, m1_rdata  same as the M0 group, for M1.
- s_valid  out  1  slave request.
- s_instr, s_addr, s_wdata, s_wstrb  out  as masters  muxed from the granted master.
- s_ready  in  1  slave completion.
- s_rdata  in  DATA_WIDTH  slave read data.
- grant  out  2  one-hot current owner; 00 means idle.

Behaviour:
- **Reset (nreset low, async):**
  - state=IDLE, grant=00, s_valid=0, all m*_ready/m*_err=0.
  - Priority pointer = M0; timeout counter = 0.
  - Applies immediately, including mid-transaction; the aborted transaction is never completed.
- **States:** IDLE, OWN0, OWN1, registered.
- **IDLE:**
  - Only m0_valid set → OWN0.
  - Only m1_valid set → OWN1.
  - Both set → the master named by the priority pointer wins.
  - s_valid=0 in IDLE.
  - Arbitration latency: one cycle from m*_valid to s_valid.
- **OWNx:**
  - s_valid = mx_valid; s_addr/s_wdata/s_wstrb/s_instr combinationally muxed from master x.
  - mx_ready = s_ready, combinational pass-through.
  - s_rdata broadcast to both m*_rdata; the non-granted ready is held 0.
- **Normal completion** (s_valid & s_ready in OWNx):
  - Next state IDLE; priority pointer set to the other master.
  - Counter cleared.
  - Zero-wait slave: one dead IDLE cycle between back-to-back transactions.
- **Timeout** (TIMEOUT>0):
  - Counter increments each OWNx cycle without s_ready.
  - When counter == TIMEOUT and s_ready=0: mx_err=1 for exactly one cycle, s_valid forced 0 that cycle, next state IDLE, priority flips.
  - s_ready arriving in the same cycle as the timeout wins: ready, no err.
  - Counter width is clog2(TIMEOUT+1).
- **Protocol violation:** mx_valid drops while OWNx without ready → IDLE, no ready/err, priority unchanged.
- **Non-granted master:** valid held waiting; inputs ignored, no side effects.
- **Concurrency:** at most one of m0_ready, m1_ready, m0_err, m1_err is high in any cycle.
- grant mirrors the state encoding exactly.

Decomposition:
- Shared package: state encoding constants (IDLE/OWN0/OWN1) and a strobe-width helper constant (DATA_WIDTH/8).
- One natural sub-module: rr_arbiter2, a 2-request round-robin picker with priority pointer update on a "done" input, reusable for future peripheral arbiters.
- Mux and timeout logic stay in the top module.

Test Plan:
1. Reset, then M0 read at 0x00000010; slave ready after 2 waits with rdata 0xDEADBEEF → s_valid on the cycle after m0_valid; m0_ready one cycle; m0_rdata=0xDEADBEEF; grant 01→00.
2. M0 and M1 both assert in the same cycle after reset → M0 served first (grant=01), then M1 (grant=10); repeat → M1 first; strict alternation over 8 transactions.
3. M1 write 0x12345678, wstrb=0011, to 0x20 with zero-wait slave → s_wstrb=0011 and s_wdata match; m1_ready one cycle; M0 held off the whole time.
4. TIMEOUT=4, slave never ready for M0 → m0_err pulses exactly 4 cycles after grant; m0_ready never asserted; pending M1 granted next.
5. s_ready coincides with the timeout cycle → m0_ready=1, m0_err=0.
6. nreset pulled low mid-OWN1 → grant=00, s_valid=0 asynchronously; after release, M0 requests granted first.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-master PicoRV32 native-bus arbiter.
// Holds the state encoding, which doubles as the one-hot grant value.
package mem_bus_arbiter_pkg;

    localparam int unsigned N_REQ          = 2;
    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_TIMEOUT    = 255;

    // Encoding is exported directly as the grant vector.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } arb_state_e;

    function automatic int unsigned strb_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter2.sv
// Two-request round-robin picker; the pointer moves to the other requester
// whenever the current owner reports completion on i_done.
module rr_arbiter2
    import mem_bus_arbiter_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_done,
    input  logic             i_done_id,
    output logic [N_REQ-1:0] o_pick
);

    logic r_ptr;

    // Pointer names the requester that wins a tie; 0 selects requester 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= 1'b0;
        end else if (i_done) begin
            r_ptr <= ~i_done_id;
        end
    end

    always_comb begin
        o_pick = i_req;
        if (&i_req) begin
            o_pick = r_ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one PicoRV32 native memory port between two masters with
// round-robin fairness, whole-transaction grant and a per-transaction timeout.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                                  clk,
    input  logic                                  nreset,

    input  logic                                  m0_valid,
    input  logic                                  m0_instr,
    input  logic [ADDR_WIDTH-1:0]                 m0_addr,
    input  logic [DATA_WIDTH-1:0]                 m0_wdata,
    input  logic [strb_width(DATA_WIDTH)-1:0]     m0_wstrb,
    output logic                                  m0_ready,
    output logic                                  m0_err,
    output logic [DATA_WIDTH-1:0]                 m0_rdata,

    input  logic                                  m1_valid,
    input  logic                                  m1_instr,
    input  logic [ADDR_WIDTH-1:0]                 m1_addr,
    input  logic [DATA_WIDTH-1:0]                 m1_wdata,
    input  logic [strb_width(DATA_WIDTH)-1:0]     m1_wstrb,
    output logic                                  m1_ready,
    output logic                                  m1_err,
    output logic [DATA_WIDTH-1:0]                 m1_rdata,

    output logic                                  s_valid,
    output logic                                  s_instr,
    output logic [ADDR_WIDTH-1:0]                 s_addr,
    output logic [DATA_WIDTH-1:0]                 s_wdata,
    output logic [strb_width(DATA_WIDTH)-1:0]     s_wstrb,
    input  logic                                  s_ready,
    input  logic [DATA_WIDTH-1:0]                 s_rdata,

    output logic [1:0]                            grant
);

    // A zero TIMEOUT still needs a legal one-bit counter; it is never advanced.
    localparam int unsigned      CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    arb_state_e         r_state;
    arb_state_e         w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [N_REQ-1:0]   w_req;
    logic [N_REQ-1:0]   w_pick;
    logic               w_done;
    logic               w_done_id;
    logic               w_sel1;
    logic               w_own_valid;
    logic               w_tmo;

    assign w_req    = {m1_valid, m0_valid};
    assign grant    = r_state;
    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;

    rr_arbiter2 u_rr (
        .i_clk     (clk),
        .i_rst_n   (nreset),
        .i_req     (w_req),
        .i_done    (w_done),
        .i_done_id (w_done_id),
        .o_pick    (w_pick)
    );

    // State and wait-counter registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state, slave mux, completion routing and timeout detection.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done      = 1'b0;
        w_done_id   = 1'b0;
        w_sel1      = 1'b0;
        w_own_valid = 1'b0;
        w_tmo       = 1'b0;
        s_valid     = 1'b0;
        s_instr     = 1'b0;
        s_addr      = '0;
        s_wdata     = '0;
        s_wstrb     = '0;
        m0_ready    = 1'b0;
        m1_ready    = 1'b0;
        m0_err      = 1'b0;
        m1_err      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (w_pick[0]) begin
                    w_state_nxt = ST_OWN0;
                end else if (w_pick[1]) begin
                    w_state_nxt = ST_OWN1;
                end
            end

            ST_OWN0, ST_OWN1: begin
                w_sel1      = (r_state == ST_OWN1);
                w_own_valid = w_sel1 ? m1_valid : m0_valid;
                s_instr     = w_sel1 ? m1_instr : m0_instr;
                s_addr      = w_sel1 ? m1_addr  : m0_addr;
                s_wdata     = w_sel1 ? m1_wdata : m0_wdata;
                s_wstrb     = w_sel1 ? m1_wstrb : m0_wstrb;
                // A late s_ready on the expiry cycle still completes normally.
                w_tmo       = (TIMEOUT != 0) && (r_cnt == CNT_MAX) && !s_ready;
                s_valid     = w_own_valid && !w_tmo;

                if (!w_own_valid) begin
                    // Owner withdrew its request: release without completing.
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (s_ready) begin
                    m0_ready    = !w_sel1;
                    m1_ready    = w_sel1;
                    w_done      = 1'b1;
                    w_done_id   = w_sel1;
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_tmo) begin
                    m0_err      = !w_sel1;
                    m1_err      = w_sel1;
                    w_done      = 1'b1;
                    w_done_id   = w_sel1;
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (TIMEOUT != 0) begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: queued master requests, a programmable
// slave, and a cycle-level reference model checked on every falling edge.
module tb_mem_bus_arbiter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        m0_valid = 1'b0, m0_instr = 1'b0, m1_valid = 1'b0, m1_instr = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
    logic        m0_ready, m0_err, m1_ready, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid, s_instr;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready = 1'b0;
    logic [31:0] s_rdata = '0;
    logic [1:0]  grant;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .nreset(nreset),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata), .grant(grant)
    );

    typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; logic instr; } req_t;
    typedef struct { int m; bit err; int va; int cyc; logic [31:0] rdata;
                     logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; } ent_t;

    req_t q0[$], q1[$];
    ent_t log_q[$];
    int   cyc = 0, checks = 0, errors = 0;
    int   va0 = 0, va1 = 0;
    bit   busy0 = 0, busy1 = 0, done0 = 0, done1 = 0;
    int   slv_wait = 0;
    bit   slv_never = 0;
    logic [31:0] slv_rdata = '0;
    int   mo = 0, mptr = 0, gcyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int m, input logic [31:0] a, input logic [31:0] w,
                        input logic [3:0] s, input logic ins);
        req_t r;
        r.addr = a; r.wdata = w; r.wstrb = s; r.instr = ins;
        if (m == 0) q0.push_back(r); else q1.push_back(r);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || busy0 || busy1 || grant != 2'b00) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(n < 300), 64'd1);
        @(negedge clk);
    endtask

    // Master driver: hold valid until completion is seen, then load the next request.
    initial begin
        req_t r;
        forever begin
            @(posedge clk); #1;
            if (!nreset) begin
                busy0 = 0; busy1 = 0; done0 = 0; done1 = 0;
                m0_valid = 1'b0; m1_valid = 1'b0;
            end else begin
                if (busy0 && done0) begin m0_valid = 1'b0; busy0 = 0; end
                if (busy1 && done1) begin m1_valid = 1'b0; busy1 = 0; end
                done0 = 0; done1 = 0;
                if (!busy0 && q0.size() != 0) begin
                    r = q0.pop_front();
                    m0_valid = 1'b1; m0_addr = r.addr; m0_wdata = r.wdata;
                    m0_wstrb = r.wstrb; m0_instr = r.instr; busy0 = 1; va0 = cyc;
                end
                if (!busy1 && q1.size() != 0) begin
                    r = q1.pop_front();
                    m1_valid = 1'b1; m1_addr = r.addr; m1_wdata = r.wdata;
                    m1_wstrb = r.wstrb; m1_instr = r.instr; busy1 = 1; va1 = cyc;
                end
            end
        end
    end

    // Slave: answers slv_wait cycles after the grant, or never.
    initial begin
        int sc = 0;
        forever begin
            @(posedge clk); #2;
            if (grant == 2'b00) begin
                s_ready = 1'b0; sc = 0;
            end else if (!slv_never) begin
                if (sc == slv_wait) begin s_ready = 1'b1; s_rdata = slv_rdata; end
                sc++;
            end
        end
    end

    // Reference model and per-cycle compare.
    initial begin
        int x, nmo;
        logic [1:0] eg, erdy, eerr, vals;
        logic esv;
        ent_t e;
        forever begin
            @(negedge clk);
            if (!nreset) begin
                chk("rst_grant", 64'(grant), 64'd0);
                chk("rst_s_valid", 64'(s_valid), 64'd0);
                chk("rst_done", 64'({m0_ready, m1_ready, m0_err, m1_err}), 64'd0);
                mo = 0; mptr = 0;
            end else begin
                eg = 2'b00; esv = 1'b0; erdy = 2'b00; eerr = 2'b00; nmo = mo; x = 0;
                vals = {m1_valid, m0_valid};
                if (mo == 0) begin
                    if (vals == 2'b11) nmo = mptr + 1;
                    else if (vals[0])  nmo = 1;
                    else if (vals[1])  nmo = 2;
                    if (nmo != 0) gcyc = cyc + 1;
                end else begin
                    x = mo - 1;
                    eg[x] = 1'b1;
                    if (!vals[x]) begin
                        nmo = 0;
                    end else if (s_ready) begin
                        esv = 1'b1; erdy[x] = 1'b1; nmo = 0; mptr = 1 - x;
                    end else if (cyc - gcyc == TMO) begin
                        eerr[x] = 1'b1; nmo = 0; mptr = 1 - x;
                    end else begin
                        esv = 1'b1;
                    end
                end
                chk("grant", 64'(grant), 64'(eg));
                chk("s_valid", 64'(s_valid), 64'(esv));
                chk("ready", 64'({m1_ready, m0_ready}), 64'(erdy));
                chk("err", 64'({m1_err, m0_err}), 64'(eerr));
                chk("rdata", 64'({m0_rdata, m1_rdata}), 64'({s_rdata, s_rdata}));
                if (esv) begin
                    chk("s_addr", 64'(s_addr), 64'(x == 0 ? m0_addr : m1_addr));
                    chk("s_wdata", 64'(s_wdata), 64'(x == 0 ? m0_wdata : m1_wdata));
                    chk("s_wstrb", 64'(s_wstrb), 64'(x == 0 ? m0_wstrb : m1_wstrb));
                    chk("s_instr", 64'(s_instr), 64'(x == 0 ? m0_instr : m1_instr));
                end
                mo = nmo;
            end
            if (m0_ready || m0_err || m1_ready || m1_err) begin
                e.m = (m1_ready || m1_err) ? 1 : 0;
                e.err = m0_err || m1_err;
                e.va = (e.m == 0) ? va0 : va1;
                e.cyc = cyc; e.rdata = (e.m == 0) ? m0_rdata : m1_rdata;
                e.addr = s_addr; e.wdata = s_wdata; e.wstrb = s_wstrb;
                log_q.push_back(e);
                if (e.m == 0) done0 = 1; else done1 = 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle %0d: got running expected finished", cyc);
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk); nreset = 1'b0;
        q0.delete(); q1.delete();
        repeat (3) @(negedge clk);
        chk("reset_grant_lit", 64'(grant), 64'd0);
        @(posedge clk); #3; nreset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int base, n;
        do_reset();

        // 1: M0 instruction read, two slave wait states.
        slv_wait = 2; slv_rdata = 32'hDEADBEEF; base = log_q.size();
        push(0, 32'h10, 32'h0, 4'b0000, 1'b1);
        wait_idle("idle_t1");
        chk("t1_count", 64'(log_q.size() - base), 64'd1);
        if (log_q.size() > base) begin
            chk("t1_master", 64'(log_q[base].m), 64'd0);
            chk("t1_err", 64'(log_q[base].err), 64'd0);
            chk("t1_latency", 64'(log_q[base].cyc - log_q[base].va), 64'd3);
            chk("t1_rdata", 64'(log_q[base].rdata), 64'hDEADBEEF);
            chk("t1_addr", 64'(log_q[base].addr), 64'h10);
        end

        // 2: simultaneous requests from reset alternate strictly.
        do_reset();
        slv_wait = 0; base = log_q.size();
        for (int r = 0; r < 4; r++) begin
            slv_rdata = 32'h100 + 32'(r);
            push(0, 32'h40 + 32'(r), 32'h0, 4'b0000, 1'b0);
            push(1, 32'h80 + 32'(r), 32'h0, 4'b0000, 1'b0);
            wait_idle("idle_t2");
        end
        chk("t2_count", 64'(log_q.size() - base), 64'd8);
        for (int i = 0; i < 8; i++)
            if (log_q.size() > base + i) chk("t2_order", 64'(log_q[base + i].m), 64'(i % 2));
        push(0, 32'h44, 32'h0, 4'b0000, 1'b0);
        wait_idle("idle_t2b");
        base = log_q.size();
        push(0, 32'h48, 32'h0, 4'b0000, 1'b0);
        push(1, 32'h88, 32'h0, 4'b0000, 1'b0);
        wait_idle("idle_t2c");
        if (log_q.size() >= base + 2) begin
            chk("t2_m1_first", 64'(log_q[base].m), 64'd1);
            chk("t2_m0_second", 64'(log_q[base + 1].m), 64'd0);
        end else chk("t2c_count", 64'(log_q.size() - base), 64'd2);

        // 3: M1 partial write, M0 held off until it finishes.
        base = log_q.size();
        push(1, 32'h20, 32'h12345678, 4'b0011, 1'b0);
        @(negedge clk);
        push(0, 32'h24, 32'h0, 4'b0000, 1'b0);
        wait_idle("idle_t3");
        if (log_q.size() >= base + 2) begin
            chk("t3_master", 64'(log_q[base].m), 64'd1);
            chk("t3_wstrb", 64'(log_q[base].wstrb), 64'h3);
            chk("t3_wdata", 64'(log_q[base].wdata), 64'h12345678);
            chk("t3_addr", 64'(log_q[base].addr), 64'h20);
            chk("t3_latency", 64'(log_q[base].cyc - log_q[base].va), 64'd1);
            chk("t3_m0_after", 64'(log_q[base + 1].cyc - log_q[base].cyc), 64'd2);
        end else chk("t3_count", 64'(log_q.size() - base), 64'd2);

        // 4: slave never answers; M0 times out, pending M1 follows.
        slv_never = 1; base = log_q.size();
        push(0, 32'h30, 32'h0, 4'b0000, 1'b0);
        @(negedge clk);
        push(1, 32'h34, 32'h0, 4'b0000, 1'b0);
        wait_idle("idle_t4");
        if (log_q.size() >= base + 2) begin
            chk("t4_m0", 64'(log_q[base].m), 64'd0);
            chk("t4_m0_err", 64'(log_q[base].err), 64'd1);
            chk("t4_err_time", 64'(log_q[base].cyc - log_q[base].va), 64'd5);
            chk("t4_m1_next", 64'(log_q[base + 1].m), 64'd1);
            chk("t4_m1_gap", 64'(log_q[base + 1].cyc - log_q[base].cyc), 64'd6);
        end else chk("t4_count", 64'(log_q.size() - base), 64'd2);

        // 5: ready lands on the expiry cycle and wins.
        slv_never = 0; slv_wait = TMO; slv_rdata = 32'hCAFEF00D; base = log_q.size();
        push(0, 32'h50, 32'h0, 4'b0000, 1'b0);
        wait_idle("idle_t5");
        if (log_q.size() > base) begin
            chk("t5_err", 64'(log_q[base].err), 64'd0);
            chk("t5_time", 64'(log_q[base].cyc - log_q[base].va), 64'd5);
            chk("t5_rdata", 64'(log_q[base].rdata), 64'hCAFEF00D);
        end else chk("t5_count", 64'(log_q.size() - base), 64'd1);

        // 6: asynchronous reset in the middle of an M1 transaction.
        slv_never = 1; base = log_q.size();
        push(1, 32'h60, 32'h0, 4'b0000, 1'b0);
        n = 0;
        while (grant != 2'b10 && n < 50) begin @(negedge clk); n++; end
        chk("t6_granted", 64'(grant), 64'h2);
        #3 nreset = 1'b0;
        #1;
        chk("t6_async_grant", 64'(grant), 64'd0);
        chk("t6_async_s_valid", 64'(s_valid), 64'd0);
        q0.delete(); q1.delete();
        repeat (2) @(negedge clk);
        @(posedge clk); #3; nreset = 1'b1;
        slv_never = 0; slv_wait = 1;
        @(negedge clk);
        chk("t6_aborted", 64'(log_q.size() - base), 64'd0);
        push(0, 32'h70, 32'h0, 4'b0000, 1'b0);
        push(1, 32'h74, 32'h0, 4'b0000, 1'b0);
        wait_idle("idle_t6");
        if (log_q.size() >= base + 2) begin
            chk("t6_m0_first", 64'(log_q[base].m), 64'd0);
            chk("t6_m1_second", 64'(log_q[base + 1].m), 64'd1);
        end else chk("t6_count", 64'(log_q.size() - base), 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
